mul_share_ctrl: RTL and testbench
=================================

# mul_share_ctrl

Sequencing and arbitration controller for the shared 32x32 signed Booth multiplier in the datapath. Two requesters (CPU control unit port 0, auxiliary/test port 1) submit operand pairs. The block grants one requester at a time round-robin, drives the multiplier inputs, waits out the multiplier's registered latency, and writes the 64-bit product into the HI/LO register pair with a one-cycle done pulse to the winning requester.

## Interface
Parameters:
- MUL_LAT, 1: clock edges from operands stable at multiplier inputs to product valid on mul_y; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  request from requester 0 / 1; held high with operands stable until matching ack
- mplr0 / mplr1  in  32  multiplier operand from requester 0 / 1
- mcnd0 / mcnd1  in  32  multiplicand operand from requester 0 / 1
- ack0 / ack1  out  1  one-cycle grant pulse; operands captured
- done0 / done1  out  1  one-cycle pulse; HI/LO hold the requester's product
- busy  out  1  high whenever state is not IDLE
- mul_mplr  out  32  registered operand to multiplier Mplr
- mul_mcnd  out  32  registered operand to multiplier Mcnd
- mul_y  in  64  product from multiplier Y
- hi  out  32  product bits [63:32]
- lo  out  32  product bits [31:0]
- hi_lo_we  out  1  one-cycle write strobe, coincident with done0/done1

## Operation
- States: IDLE, WAIT, DONE. Reset value of every output and internal register is 0 (state IDLE, priority pointer = 0, counter = 0).
- IDLE: if neither req is high, remain in IDLE. Otherwise:
  - Select a winner. If only one req is high, it wins. If both are high, the requester not granted last wins; after reset, port 0 wins.
  - Register the winner's operands into mul_mplr/mul_mcnd, pulse its ack for one cycle, load counter with MUL_LAT, record the winner, go to WAIT.
- WAIT: at each edge, if counter != 0, decrement it. At the edge where counter == 0, register mul_y into hi/lo, set hi_lo_we and the winner's done, and go to DONE.
- DONE: one cycle. At the next edge, clear hi_lo_we/done, toggle the priority pointer to the loser, and return to IDLE.
- Requests are sampled only in IDLE. req inputs during WAIT/DONE are ignored.
- A requester must drop req by the edge after it sees ack. A req still high when the block returns to IDLE counts as a new request.
- Arithmetic: the product is passed through unmodified as 64-bit two's complement. There is no truncation or overflow flag.
- hi, lo, mul_mplr and mul_mcnd hold their last values until the next write or grant.
- Reset mid-operation aborts immediately:
  - state returns to IDLE and all outputs go to 0;
  - no done or hi_lo_we is issued for the aborted request;
  - the priority pointer returns to 0.

## Timing
- The request is sampled at edge E0 (state IDLE).
- ack and new mul_mplr/mul_mcnd are valid in the cycle after E0.
- The counter reaches 0 at edge E0+MUL_LAT.
- hi/lo update and done/hi_lo_we go high after edge E0+MUL_LAT+1, for exactly one cycle.
- The block is back in IDLE after edge E0+MUL_LAT+2. The earliest next grant is at edge E0+MUL_LAT+2, giving a throughput of one product per MUL_LAT+2 cycles.
- busy is high from after E0 through the DONE cycle inclusive.
- ack0/ack1 are never high together; neither are done0/done1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single request, MUL_LAT=1: req0 with mplr0=7, mcnd0=0xFFFFFFFD (-3) sampled at E0. Required:
  - ack0 in the cycle after E0;
  - after E0+2, hi=0xFFFFFFFF, lo=0xFFFFFFEB with done0=hi_lo_we=1 for one cycle;
  - done1 stays 0.
- Simultaneous requests after reset: req0 and req1 high at E0.
  - Port 0 is acked first.
  - Port 1, still high, is acked at E0+3 (MUL_LAT=1).
  - Products appear in order; pointer alternation is verified over four back-to-back pairs.
- Corner operands: 0x80000000 x 0x80000000 gives hi=0x40000000, lo=0. 0xFFFFFFFF x 0xFFFFFFFF gives hi=0, lo=1. 0 x 0x12345678 gives hi=lo=0.
- Latency parameter: MUL_LAT=3, req1 sampled at E0.
  - done1 is asserted only after E0+4.
  - busy is high for exactly 5 cycles.
  - The bench model's mul_y changes before E0+3 do not affect the result.
- Reset mid-WAIT: assert reset one cycle after ack0.
  - All outputs are 0 immediately (asynchronously).
  - No done0 pulse follows after reset is released.
  - A subsequent req1 is granted and completes normally.
- Ignored requests: req1 pulses high only during WAIT/DONE of a port-0 operation. Required: no ack1 and no state disturbance; hi/lo hold the port-0 product.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer for the shared 32x32 signed multiplier.
// Two requesters submit operand pairs. One winner at a time is granted. Its
// operands are registered onto the multiplier inputs. After MUL_LAT edges the
// 64-bit product is latched into HI/LO, and the winner gets a one-cycle done.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   req0/req1             requests, held with operands stable until ack
//   mplr0/1, mcnd0/1      operand pairs from requester 0 / 1
//   ack0/ack1             one-cycle grant pulse (operands captured)
//   done0/done1           one-cycle pulse, HI/LO hold that requester's product
//   busy                  high whenever the controller is not idle
//   mul_mplr, mul_mcnd    registered operands to the multiplier
//   mul_y                 64-bit product from the multiplier
//   hi, lo                product bits [63:32] / [31:0]
//   hi_lo_we              HI/LO write strobe, coincident with done0/done1
module mul_share_ctrl #(
    parameter int unsigned MUL_LAT = 1  // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] mplr0,
    input  logic [31:0] mplr1,
    input  logic [31:0] mcnd0,
    input  logic [31:0] mcnd1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic [31:0] mul_mplr,
    output logic [31:0] mul_mcnd,
    input  logic [63:0] mul_y,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hi_lo_we
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;      // port that wins a tie
    logic                win_q, win_d;        // port currently being served
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                we_q, we_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   mplr_q, mplr_d;
    logic [DATA_W-1:0]   mcnd_q, mcnd_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                arb_prio;
    logic                pick1;
    logic                any_req;
    logic                grant;

    // Arbitration. The edge leaving DONE arbitrates as if idle, using the
    // already-toggled pointer, so back-to-back products sustain one per
    // MUL_LAT+2 cycles.
    always_comb begin
        arb_prio = (state_q == DONE) ? ~win_q : prio_q;
        any_req  = req0 | req1;
        pick1    = req1 & (~req0 | arb_prio);
        grant    = any_req & ((state_q == IDLE) | (state_q == DONE));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        we_d    = 1'b0;
        mplr_d  = mplr_q;
        mcnd_d  = mcnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = mul_y[PROD_W-1:DATA_W];
                    lo_d    = mul_y[DATA_W-1:0];
                    we_d    = 1'b1;
                    done0_d = ~win_q;
                    done1_d = win_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                prio_d  = ~win_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            win_d   = pick1;
            mplr_d  = pick1 ? mplr1 : mplr0;
            mcnd_d  = pick1 ? mcnd1 : mcnd0;
            ack0_d  = ~pick1;
            ack1_d  = pick1;
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = WAIT;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            win_q   <= 1'b0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            mplr_q  <= '0;
            mcnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            mplr_q  <= mplr_d;
            mcnd_q  <= mcnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign busy     = busy_q;
    assign hi_lo_we = we_q;
    assign mul_mplr = mplr_q;
    assign mul_mcnd = mcnd_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: instance A (MUL_LAT=1) with a one-stage
// multiplier model, instance B (MUL_LAT=3) with mul_y driven step by step.
module tb_mul_share_ctrl;

    logic        clk;
    logic        reset;

    logic        req0_a, req1_a;
    logic [31:0] mplr0_a, mplr1_a, mcnd0_a, mcnd1_a;
    logic        ack0_a, ack1_a, done0_a, done1_a, busy_a, we_a;
    logic [31:0] mul_mplr_a, mul_mcnd_a, hi_a, lo_a;
    logic [63:0] mul_y_a;

    logic        req0_b, req1_b;
    logic [31:0] mplr0_b, mplr1_b, mcnd0_b, mcnd1_b;
    logic        ack0_b, ack1_b, done0_b, done1_b, busy_b, we_b;
    logic [31:0] mul_mplr_b, mul_mcnd_b, hi_b, lo_b;
    logic [63:0] mul_y_b;

    int n_checks;
    int n_errors;

    logic [31:0] a0 [4];
    logic [31:0] b0 [4];
    logic [63:0] x0 [4];
    logic [31:0] a1 [4];
    logic [31:0] b1 [4];
    logic [63:0] x1 [4];

    mul_share_ctrl #(.MUL_LAT(1)) dut_a (
        .clk(clk), .reset(reset),
        .req0(req0_a), .req1(req1_a),
        .mplr0(mplr0_a), .mplr1(mplr1_a), .mcnd0(mcnd0_a), .mcnd1(mcnd1_a),
        .ack0(ack0_a), .ack1(ack1_a), .done0(done0_a), .done1(done1_a),
        .busy(busy_a), .mul_mplr(mul_mplr_a), .mul_mcnd(mul_mcnd_a),
        .mul_y(mul_y_a), .hi(hi_a), .lo(lo_a), .hi_lo_we(we_a)
    );

    mul_share_ctrl #(.MUL_LAT(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0(req0_b), .req1(req1_b),
        .mplr0(mplr0_b), .mplr1(mplr1_b), .mcnd0(mcnd0_b), .mcnd1(mcnd1_b),
        .ack0(ack0_b), .ack1(ack1_b), .done0(done0_b), .done1(done1_b),
        .busy(busy_b), .mul_mplr(mul_mplr_b), .mul_mcnd(mul_mcnd_b),
        .mul_y(mul_y_b), .hi(hi_b), .lo(lo_b), .hi_lo_we(we_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // One-stage signed multiplier model for instance A.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mul_y_a <= '0;
        else       mul_y_a <= sx(mul_mplr_a) * sx(mul_mcnd_a);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int p;
        int i;
        int busy_cnt;

        n_checks = 0;
        n_errors = 0;

        a0[0] = 32'h8000_0000; b0[0] = 32'h8000_0000; x0[0] = 64'h4000_0000_0000_0000;
        a0[1] = 32'h0000_0000; b0[1] = 32'h1234_5678; x0[1] = 64'h0000_0000_0000_0000;
        a0[2] = 32'h0000_0007; b0[2] = 32'hFFFF_FFFD; x0[2] = 64'hFFFF_FFFF_FFFF_FFEB;
        a0[3] = 32'h0000_0002; b0[3] = 32'h0000_0003; x0[3] = 64'h0000_0000_0000_0006;
        a1[0] = 32'hFFFF_FFFF; b1[0] = 32'hFFFF_FFFF; x1[0] = 64'h0000_0000_0000_0001;
        a1[1] = 32'h0001_0000; b1[1] = 32'h0001_0000; x1[1] = 64'h0000_0001_0000_0000;
        a1[2] = 32'h7FFF_FFFF; b1[2] = 32'h0000_0002; x1[2] = 64'h0000_0000_FFFF_FFFE;
        a1[3] = 32'hFFFF_FFFE; b1[3] = 32'h0000_0005; x1[3] = 64'hFFFF_FFFF_FFFF_FFF6;

        reset = 1'b1;
        req0_a = 0; req1_a = 0; mplr0_a = 0; mplr1_a = 0; mcnd0_a = 0; mcnd1_a = 0;
        req0_b = 0; req1_b = 0; mplr0_b = 0; mplr1_b = 0; mcnd0_b = 0; mcnd1_b = 0;
        mul_y_b = '0;

        // Reset state
        repeat (2) cyc();
        check("rst_busy", busy_a, 0);
        check("rst_ack", {ack0_a, ack1_a}, 0);
        check("rst_done", {done0_a, done1_a, we_a}, 0);
        check("rst_hilo", {hi_a, lo_a}, 0);
        check("rst_ops", {mul_mplr_a, mul_mcnd_a}, 0);
        reset = 1'b0;
        cyc();
        check("idle_busy", busy_a, 0);

        // Single request on port 0, 7 * -3
        req0_a = 1; mplr0_a = 32'd7; mcnd0_a = 32'hFFFF_FFFD;
        cyc();
        check("s_ack0", ack0_a, 1);
        check("s_ack1", ack1_a, 0);
        check("s_busy", busy_a, 1);
        check("s_ops", {mul_mplr_a, mul_mcnd_a}, {32'd7, 32'hFFFF_FFFD});
        req0_a = 0;
        cyc();
        check("s_ack0_drop", ack0_a, 0);
        check("s_early_done", {done0_a, we_a}, 0);
        cyc();
        check("s_done0", done0_a, 1);
        check("s_we", we_a, 1);
        check("s_done1", done1_a, 0);
        check("s_hilo", {hi_a, lo_a}, 64'hFFFF_FFFF_FFFF_FFEB);
        cyc();
        check("s_done_drop", {done0_a, done1_a, we_a}, 0);
        check("s_idle", busy_a, 0);
        check("s_hold", {hi_a, lo_a}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Simultaneous requests after reset, four back-to-back pairs
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req0_a = 1; mplr0_a = a0[0]; mcnd0_a = b0[0];
        req1_a = 1; mplr1_a = a1[0]; mcnd1_a = b1[0];
        for (int k = 0; k < 8; k++) begin
            p = k % 2;
            i = k / 2;
            cyc();
            check($sformatf("bb%0d_ack0", k), ack0_a, (p == 0) ? 1 : 0);
            check($sformatf("bb%0d_ack1", k), ack1_a, (p == 1) ? 1 : 0);
            check($sformatf("bb%0d_ops", k), {mul_mplr_a, mul_mcnd_a},
                  (p == 0) ? {a0[i], b0[i]} : {a1[i], b1[i]});
            if (p == 0) begin
                if (i < 3) begin mplr0_a = a0[i+1]; mcnd0_a = b0[i+1]; end
                else req0_a = 0;
            end else begin
                if (i < 3) begin mplr1_a = a1[i+1]; mcnd1_a = b1[i+1]; end
                else req1_a = 0;
            end
            cyc();
            check($sformatf("bb%0d_nodone", k), {done0_a, done1_a, we_a}, 0);
            cyc();
            check($sformatf("bb%0d_done", k), {done0_a, done1_a, we_a},
                  (p == 0) ? 3'b101 : 3'b011);
            check($sformatf("bb%0d_hilo", k), {hi_a, lo_a}, (p == 0) ? x0[i] : x1[i]);
        end
        cyc();
        check("bb_idle", busy_a, 0);
        check("bb_noack", {ack0_a, ack1_a}, 0);

        // Reset mid-WAIT
        req0_a = 1; mplr0_a = 32'd3; mcnd0_a = 32'd4;
        cyc();
        check("r_ack0", ack0_a, 1);
        req0_a = 0;
        cyc();
        #2;
        reset = 1'b1;
        #1;
        check("r_async_busy", busy_a, 0);
        check("r_async_ctl", {ack0_a, ack1_a, done0_a, done1_a, we_a}, 0);
        check("r_async_hilo", {hi_a, lo_a}, 0);
        check("r_async_ops", {mul_mplr_a, mul_mcnd_a}, 0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("r_nodone%0d", k), {done0_a, we_a, busy_a}, 0);
        end
        req1_a = 1; mplr1_a = 32'hFFFF_FFFF; mcnd1_a = 32'd2;
        cyc();
        check("r_ack1", {ack0_a, ack1_a}, 2'b01);
        req1_a = 0;
        cyc();
        cyc();
        check("r_done1", {done0_a, done1_a, we_a}, 3'b011);
        check("r_hilo", {hi_a, lo_a}, 64'hFFFF_FFFF_FFFF_FFFE);
        cyc();
        check("r_idle", busy_a, 0);

        // Requests during WAIT/DONE are ignored
        req0_a = 1; mplr0_a = 32'd5; mcnd0_a = 32'd6;
        cyc();
        check("ig_ack0", ack0_a, 1);
        req0_a = 0;
        req1_a = 1; mplr1_a = 32'h1111_1111; mcnd1_a = 32'h2222_2222;
        cyc();
        check("ig_wait_ack1", ack1_a, 0);
        check("ig_wait_busy", busy_a, 1);
        cyc();
        check("ig_done0", {done0_a, done1_a, we_a}, 3'b101);
        check("ig_hilo", {hi_a, lo_a}, 64'h0000_0000_0000_001E);
        check("ig_done_ack1", ack1_a, 0);
        req1_a = 0;
        cyc();
        check("ig_after_ack1", ack1_a, 0);
        check("ig_after_busy", busy_a, 0);
        check("ig_hold", {hi_a, lo_a}, 64'h0000_0000_0000_001E);
        cyc();
        check("ig_late_ack1", ack1_a, 0);

        // MUL_LAT=3 on instance B; early mul_y values must be ignored
        busy_cnt = 0;
        req1_b = 1; mplr1_b = 32'hFFFF_FFF9; mcnd1_b = 32'd9;
        cyc();
        check("l_ack1", {ack0_b, ack1_b}, 2'b01);
        busy_cnt += int'(busy_b);
        req1_b = 0;
        mul_y_b = 64'hDEAD_BEEF_0000_0001;
        cyc();
        busy_cnt += int'(busy_b);
        check("l_nodone1", done1_b, 0);
        mul_y_b = 64'hDEAD_BEEF_0000_0002;
        cyc();
        busy_cnt += int'(busy_b);
        check("l_nodone2", done1_b, 0);
        mul_y_b = 64'hDEAD_BEEF_0000_0003;
        cyc();
        busy_cnt += int'(busy_b);
        check("l_nodone3", {done1_b, we_b}, 0);
        mul_y_b = 64'hFFFF_FFFF_FFFF_FFC1;
        cyc();
        busy_cnt += int'(busy_b);
        check("l_done1", {done0_b, done1_b, we_b}, 3'b011);
        check("l_hilo", {hi_b, lo_b}, 64'hFFFF_FFFF_FFFF_FFC1);
        mul_y_b = 64'h0123_4567_89AB_CDEF;
        cyc();
        busy_cnt += int'(busy_b);
        check("l_done_drop", {done1_b, we_b}, 0);
        check("l_busy_cycles", 64'(busy_cnt), 5);
        check("l_hold", {hi_b, lo_b}, 64'hFFFF_FFFF_FFFF_FFC1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
